// File: rtl/modulated_delay.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | modulated_delay                                                          |
// | LFO-modulated delay line: flanger / vibrato / bypass with feedback and   |
// | wet/dry mix. Define MODDELAY_INTERP_EN for fractional-tap interpolation. |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module modulated_delay #(
  parameter int SAMPLE_BITS = 12,
  parameter int DELAY_BITS  = 10,
  parameter int ACC_BITS    = 21,
  parameter int FRAC_BITS   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          din_valid,
  input  logic signed [SAMPLE_BITS-1:0] din,
  input  logic [15:0]                   phase_inc,
  input  logic [DELAY_BITS-1:0]         base_delay,
  input  logic [DELAY_BITS-1:0]         depth,
  input  logic signed [7:0]             feedback,
  input  logic [7:0]                    mix,
  input  logic [1:0]                    mode,
  output logic signed [SAMPLE_BITS-1:0] dout,
  output logic                          dout_valid,
  output logic                          busy,
  output logic                          overrun
);

  localparam int TRI_W   = DELAY_BITS + FRAC_BITS;
  localparam int LFO_W   = TRI_W + DELAY_BITS;
  localparam int OFF_W   = DELAY_BITS + 1;
  localparam int WIDE_W  = SAMPLE_BITS + 12;
  localparam int DEPTH_N = 1 << DELAY_BITS;
  localparam logic [OFF_W-1:0]         OFF_MAX = OFF_W'(DEPTH_N - 2);
  localparam logic [DELAY_BITS-1:0]    ONE_D   = DELAY_BITS'(1);
  localparam logic signed [WIDE_W-1:0] SAT_HI  = WIDE_W'((1 << (SAMPLE_BITS - 1)) - 1);
  localparam logic signed [WIDE_W-1:0] SAT_LO  = ~SAT_HI;

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_RD_A  = 3'd2,
    S_RD_B  = 3'd3,
    S_CALC  = 3'd4,
    S_WR    = 3'd5
  } state_t;

  state_t                        state_q, state_d;
  logic [DELAY_BITS-1:0]         wp_q;
  logic [ACC_BITS-1:0]           acc_q;
  logic signed [SAMPLE_BITS-1:0] din_q, tap_q, dout_q, rd_data_q;
  logic [15:0]                   phase_q;
  logic signed [7:0]             fb_q;
  logic [7:0]                    mix_q;
  logic [1:0]                    mode_q;
  logic [DELAY_BITS-1:0]         addr_a_q;
  logic                          dout_valid_q, overrun_q;

  logic                          ram_we;
  logic signed [SAMPLE_BITS-1:0] ram_wdata;
  logic [DELAY_BITS-1:0]         rd_addr;
  logic signed [SAMPLE_BITS-1:0] mem [DEPTH_N];

  // LFO triangle and tap offset, evaluated against the accumulator at accept
  logic [TRI_W-1:0]      lfo_slice, lfo_tri;
  logic [LFO_W-1:0]      lfo_prod;
  logic [DELAY_BITS-1:0] lfo_oi, off_w, addr_a_w;
  logic [OFF_W-1:0]      off_sum;

  assign lfo_slice = acc_q[ACC_BITS-2 -: TRI_W];
  assign lfo_tri   = acc_q[ACC_BITS-1] ? ~lfo_slice : lfo_slice;
  assign lfo_prod  = {{DELAY_BITS{1'b0}}, lfo_tri} * {{TRI_W{1'b0}}, depth};
  assign lfo_oi    = DELAY_BITS'(lfo_prod >> (DELAY_BITS + FRAC_BITS));
  assign off_sum   = {1'b0, base_delay} + {1'b0, lfo_oi};
  assign off_w     = (off_sum > OFF_MAX) ? OFF_MAX[DELAY_BITS-1:0] : off_sum[DELAY_BITS-1:0];
  assign addr_a_w  = wp_q - ONE_D - off_w;

  logic signed [SAMPLE_BITS-1:0] tap_w;

`ifdef MODDELAY_INTERP_EN
  localparam int TAP_W = SAMPLE_BITS + FRAC_BITS + 2;
  logic [FRAC_BITS-1:0]          lfo_f, f_q;
  logic [DELAY_BITS-1:0]         addr_b_w;
  logic signed [SAMPLE_BITS-1:0] da_q;
  logic signed [TAP_W-1:0]       tap_diff, tap_step;

  assign lfo_f    = FRAC_BITS'(lfo_prod >> DELAY_BITS);
  assign addr_b_w = addr_a_q - ONE_D;
  assign tap_diff = TAP_W'(rd_data_q) - TAP_W'(da_q);
  assign tap_step = tap_diff * $signed({{(TAP_W - FRAC_BITS){1'b0}}, f_q});
  assign tap_w    = SAMPLE_BITS'(TAP_W'(da_q) + (tap_step >>> FRAC_BITS));
`else
  assign tap_w = rd_data_q;
`endif

  function automatic logic signed [SAMPLE_BITS-1:0] sat_fn(input logic signed [WIDE_W-1:0] v);
    if (v > SAT_HI)      sat_fn = SAT_HI[SAMPLE_BITS-1:0];
    else if (v < SAT_LO) sat_fn = SAT_LO[SAMPLE_BITS-1:0];
    else                 sat_fn = v[SAMPLE_BITS-1:0];
  endfunction

  logic signed [WIDE_W-1:0]      fb_sum, mix_sum, dry_gain, wet_gain;
  logic signed [SAMPLE_BITS-1:0] wv_w, out_w;

  assign fb_sum   = WIDE_W'(din_q) + ((WIDE_W'(tap_q) * WIDE_W'(fb_q)) >>> 7);
  assign dry_gain = WIDE_W'(9'd256 - {1'b0, mix_q});
  assign wet_gain = WIDE_W'(mix_q);
  assign mix_sum  = WIDE_W'(din_q) * dry_gain + WIDE_W'(tap_q) * wet_gain;
  assign wv_w     = sat_fn(fb_sum);

  always_comb begin
    out_w = sat_fn(mix_sum >>> 8);
    case (mode_q)
      2'd0:    out_w = din_q;
      2'd2:    out_w = tap_q;
      default: out_w = sat_fn(mix_sum >>> 8);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ram_we    = 1'b0;
    ram_wdata = '0;
    rd_addr   = addr_a_q;
    case (state_q)
      S_CLEAR: begin
        ram_we = 1'b1;
        if (wp_q == '1) state_d = S_IDLE;
      end
      S_IDLE: if (din_valid) state_d = S_RD_A;
`ifdef MODDELAY_INTERP_EN
      S_RD_A: state_d = S_RD_B;
      S_RD_B: begin
        rd_addr = addr_b_w;
        state_d = S_CALC;
      end
`else
      S_RD_A: state_d = S_CALC;
      S_RD_B: state_d = S_CALC;
`endif
      S_CALC: state_d = S_WR;
      S_WR: begin
        ram_we    = 1'b1;
        ram_wdata = wv_w;
        state_d   = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Plain synchronous RAM: no reset so it maps onto block memory
  always_ff @(posedge clk) begin
    if (ram_we) mem[wp_q] <= ram_wdata;
    rd_data_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_CLEAR;
      wp_q         <= '0;
      acc_q        <= '0;
      din_q        <= '0;
      tap_q        <= '0;
      dout_q       <= '0;
      phase_q      <= '0;
      fb_q         <= '0;
      mix_q        <= '0;
      mode_q       <= '0;
      addr_a_q     <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef MODDELAY_INTERP_EN
      f_q          <= '0;
      da_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      dout_valid_q <= 1'b0;
      if (din_valid && (state_q != S_IDLE)) overrun_q <= 1'b1;
      case (state_q)
        S_CLEAR: wp_q <= wp_q + ONE_D;
        S_IDLE: begin
          if (din_valid) begin
            din_q    <= din;
            phase_q  <= phase_inc;
            fb_q     <= feedback;
            mix_q    <= mix;
            mode_q   <= mode;
            addr_a_q <= addr_a_w;
`ifdef MODDELAY_INTERP_EN
            f_q      <= lfo_f;
`endif
          end
        end
`ifdef MODDELAY_INTERP_EN
        S_RD_B: da_q <= rd_data_q;
`endif
        S_CALC: tap_q <= tap_w;
        S_WR: begin
          dout_q       <= out_w;
          dout_valid_q <= 1'b1;
          wp_q         <= wp_q + ONE_D;
          acc_q        <= acc_q + ACC_BITS'(phase_q);
        end
        default: ;
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q != S_IDLE);
  assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_modulated_delay.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_modulated_delay                                                       |
// | Directed and randomized bench against a behavioural delay-line model.   |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module tb_modulated_delay;

  localparam int SB = 12;
  localparam int DB = 4;
  localparam int AB = 21;
  localparam int FB = 4;
  localparam int N  = 1 << DB;
  localparam int TW = DB + FB;
`ifdef MODDELAY_INTERP_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic                 clk;
  logic                 rst;
  logic                 din_valid;
  logic signed [SB-1:0] din;
  logic [15:0]          phase_inc;
  logic [DB-1:0]        base_delay;
  logic [DB-1:0]        depth;
  logic signed [7:0]    feedback;
  logic [7:0]           mix;
  logic [1:0]           mode;
  logic signed [SB-1:0] dout;
  logic                 dout_valid;
  logic                 busy;
  logic                 overrun;

  modulated_delay #(
    .SAMPLE_BITS(SB),
    .DELAY_BITS (DB),
    .ACC_BITS   (AB),
    .FRAC_BITS  (FB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din_valid (din_valid),
    .din       (din),
    .phase_inc (phase_inc),
    .base_delay(base_delay),
    .depth     (depth),
    .feedback  (feedback),
    .mix       (mix),
    .mode      (mode),
    .dout      (dout),
    .dout_valid(dout_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  int tests = 0;
  int fails = 0;

  int m_mem [N];
  int m_wp;
  int m_acc;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 2047)  return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_mem[i] = 0;
    m_wp  = 0;
    m_acc = 0;
  endtask

  // One accepted sample: triangle LFO -> offset -> taps -> write-back and output
  task automatic model_step(input int d, output int out_v);
    int pos, tv, scaled, oi, f, off, a, b, da, db, tap, wv, fbv, mixv;
    pos    = m_acc >> (AB - 1 - TW);
    tv     = (pos < (1 << TW)) ? pos : ((1 << (TW + 1)) - 1 - pos);
    scaled = (tv * int'(depth)) >> DB;
    oi     = scaled >> FB;
`ifdef MODDELAY_INTERP_EN
    f      = scaled % (1 << FB);
`else
    f      = 0;
`endif
    off = int'(base_delay) + oi;
    if (off > N - 2) off = N - 2;
    a    = (m_wp - 1 - off + 2 * N) % N;
    b    = (a - 1 + N) % N;
    da   = m_mem[a];
    db   = m_mem[b];
    tap  = da + (((db - da) * f) >>> FB);
    fbv  = int'(feedback);
    mixv = int'(mix);
    wv   = sat(d + ((tap * fbv) >>> 7));
    case (mode)
      2'd0:    out_v = d;
      2'd2:    out_v = tap;
      default: out_v = sat((d * (256 - mixv) + tap * mixv) >>> 8);
    endcase
    m_mem[m_wp] = wv;
    m_wp  = (m_wp + 1) % N;
    m_acc = (m_acc + int'(phase_inc)) % (1 << AB);
  endtask

  task automatic randomize_ctrl();
    mode       = 2'($urandom_range(0, 3));
    mix        = 8'($urandom);
    feedback   = 8'($urandom);
    base_delay = DB'($urandom);
    depth      = DB'($urandom);
    phase_inc  = 16'($urandom);
  endtask

  task automatic set_ctrl(input int md, input int mx, input int fb, input int bd, input int dp, input int ph);
    mode       = 2'(md);
    mix        = 8'(mx);
    feedback   = 8'(fb);
    base_delay = DB'(bd);
    depth      = DB'(dp);
    phase_inc  = 16'(ph);
  endtask

  task automatic reset_dut();
    int edges;
    @(negedge clk);
    rst       = 1'b1;
    din_valid = 1'b0;
    #1;
    check("rst_busy", busy, 1);
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_overrun", overrun, 0);
    @(negedge clk);
    rst   = 1'b0;
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
    end while (busy === 1'b1 && edges < 100);
    check("clear_cycles", edges, N);
    model_reset();
  endtask

  task automatic do_sample(input int d, input bit scramble, output int obs);
    int exp_v, n;
    model_step(d, exp_v);
    @(negedge clk);
    din       = SB'(d);
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    if (scramble) randomize_ctrl();
    n = 1;
    while (dout_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", n - 1, LAT);
    check("dout", dout, exp_v);
    check("busy_at_output", busy, 0);
    obs = int'(dout);
    @(negedge clk);
    check("valid_single", dout_valid, 0);
  endtask

  initial begin
    int obs, exp_v, n, pulses, edges;
    rst       = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    set_ctrl(0, 0, 0, 0, 0, 0);

    reset_dut();

    // Impulse through a pure delay of off+1 samples
    set_ctrl(2, 0, 0, 3, 0, 0);
    for (int j = 0; j < 8; j++) begin
      do_sample((j == 0) ? 1000 : 0, 1'b0, obs);
      check("impulse", obs, (j == 4) ? 1000 : 0);
    end

    // Half mix of constant input against an empty line
    reset_dut();
    set_ctrl(1, 128, 0, 3, 0, 0);
    for (int j = 0; j < 8; j++) begin
      do_sample(800, 1'b0, obs);
      check("mix_settle", obs, (j < 4) ? 400 : 800);
    end

    // Maximum positive feedback must saturate, never wrap
    reset_dut();
    set_ctrl(2, 0, 127, 3, 0, 0);
    for (int j = 0; j < 24; j++) begin
      do_sample(2047, 1'b0, obs);
      check("fb_saturate", obs, (j < 4) ? 0 : 2047);
    end

    // Fractional tap: third sample lands on f=8 with dA=0, dB=160
    reset_dut();
    set_ctrl(2, 0, 0, 0, 8, 32768);
    do_sample(160, 1'b0, obs);
    do_sample(0, 1'b0, obs);
    do_sample(0, 1'b0, obs);
`ifdef MODDELAY_INTERP_EN
    check("interp_tap", obs, 80);
`else
    check("interp_tap", obs, 0);
`endif

    // Second strobe two edges after accept is dropped; overrun sticks
    reset_dut();
    set_ctrl(0, 0, 0, 2, 0, 0);
    model_step(321, exp_v);
    @(negedge clk); din = SB'(321); din_valid = 1'b1;
    @(negedge clk); din_valid = 1'b0;
    @(negedge clk); din = SB'(555); din_valid = 1'b1;
    @(negedge clk); din_valid = 1'b0;
    check("overrun_set", overrun, 1);
    n = 3;
    while (dout_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("overrun_latency", n - 1, LAT);
    check("overrun_dout", dout, exp_v);
    set_ctrl(1, 64, 32, 1, 0, 0);
    do_sample(-700, 1'b0, obs);
    check("overrun_sticky", overrun, 1);

    // Strobe on the same edge the write completes is dropped
    reset_dut();
    set_ctrl(0, 0, 0, 0, 0, 0);
    model_step(100, exp_v);
    @(negedge clk); din = SB'(100); din_valid = 1'b1;
    @(negedge clk); din_valid = 1'b0;
    n = 1;
    while (n < LAT) begin
      @(negedge clk);
      n++;
    end
    din       = SB'(777);
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    check("same_edge_valid", dout_valid, 1);
    check("same_edge_dout", dout, exp_v);
    check("same_edge_overrun", overrun, 1);
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (dout_valid === 1'b1) pulses++;
    end
    check("same_edge_dropped", pulses, 0);
    do_sample(-5, 1'b0, obs);

    // Strobes during clear are dropped
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    edges  = 0;
    pulses = 0;
    do begin
      @(negedge clk);
      edges++;
      din_valid = (edges == 3 || edges == 7);
      if (dout_valid === 1'b1) pulses++;
    end while (busy === 1'b1 && edges < 100);
    din_valid = 1'b0;
    model_reset();
    check("clear_drop_cycles", edges, N);
    check("clear_drop_overrun", overrun, 1);
    check("clear_drop_pulses", pulses, 0);

    // Reset two edges into a sample: it never emerges
    reset_dut();
    set_ctrl(0, 0, 0, 0, 0, 0);
    do_sample(250, 1'b0, obs);
    @(negedge clk); din = SB'(999); din_valid = 1'b1;
    @(negedge clk); din_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_dout", dout, 0);
    check("midrst_valid", dout_valid, 0);
    check("midrst_busy", busy, 1);
    check("midrst_overrun", overrun, 0);
    @(negedge clk);
    rst    = 1'b0;
    edges  = 0;
    pulses = 0;
    do begin
      @(negedge clk);
      edges++;
      if (dout_valid === 1'b1) pulses++;
    end while (busy === 1'b1 && edges < 100);
    repeat (4) begin
      @(negedge clk);
      if (dout_valid === 1'b1) pulses++;
    end
    model_reset();
    check("midrst_clear_cycles", edges, N);
    check("midrst_no_output", pulses, 0);

    // Randomized controls and samples, controls scrambled while in flight
    for (int k = 0; k < 150; k++) begin
      randomize_ctrl();
      if (k % 10 == 0) do_sample(($urandom_range(0, 1) == 0) ? 2047 : -2048, 1'b1, obs);
      else             do_sample(int'($urandom_range(0, 4095)) - 2048, 1'b1, obs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
